s0_rs_enc: RTL
==============

# s0_rs_enc

Systematic Reed-Solomon encoder over GF(2^8), 4 parity symbols (t=2), the transmit-side counterpart of the s1 syndrome / s2 KES / Chien decoder chain. Accepts K message symbols on a valid/ready stream, passes them through unchanged and appends 4 parity symbols computed by an LFSR divider, so every emitted N=K+4 codeword yields all-zero rs_syn0..rs_syn3 in the decoder. Sits at the head of the loopback test path and in the TX datapath.

## Interface
- K, 251, message symbols per codeword; legal 1..251; N=K+4.
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  message symbol present.
- in_ready  out  1  encoder accepts in_data this cycle; combinational.
- in_data  in  8  message symbol, first symbol = highest-degree coefficient.
- out_valid  out  1  out_data holds a codeword symbol.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  8  codeword symbol: K message symbols, then parity p3,p2,p1,p0.
- out_sop  out  1  qualifies first symbol of codeword.
- out_eop  out  1  qualifies last (p0) symbol of codeword.

## Operation
- Field: primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D); α=0x02. Generator g(x)=(x+α^0)(x+α^1)(x+α^2)(x+α^3)=x^4+0x0F·x^3+0x36·x^2+0x78·x+0x40. Multiplies by constants use gf2m8_multi instances or equivalent constant XOR networks.
- Registers: parity p3..p0 (8b each), msg_cnt (clog2(K) bits, 0..K-1), par_cnt (2b), state, output register (out_data/out_valid/out_sop/out_eop).
- load = !out_valid | out_ready (output register free or draining this cycle).
- States: MSG (accepting message), PAR (emitting parity).
- MSG: in_ready = load. On accept (in_valid & in_ready): out_data<=in_data, out_valid<=1, out_sop<=(msg_cnt==0), out_eop<=0; fb=in_data^p3; p3<=p2^(0x0F·fb), p2<=p1^(0x36·fb), p1<=p0^(0x78·fb), p0<=0x40·fb; msg_cnt++. When accepting with msg_cnt==K-1: msg_cnt<=0, go PAR.
- MSG, no accept and load: out_valid<=0.
- PAR: in_ready=0. When load: out_data<=p3, out_valid<=1, out_sop<=0, out_eop<=(par_cnt==3); shift p3<=p2, p2<=p1, p1<=p0, p0<=0; par_cnt++. After par_cnt==3 emitted: par_cnt<=0, go MSG (parity regs now zero, no explicit clear needed).
- K=1: first accepted symbol carries out_sop and immediately moves to PAR.
- Not load (out_valid & !out_ready): all registers hold; in_ready=0.
- No gaps required in input; input may stall arbitrarily between symbols; partial codeword state is held indefinitely.

## Timing
- Reset (rst=1 at edge): state=MSG, msg_cnt=0, par_cnt=0, p3..p0=0x00, out_valid=0, out_data=0x00, out_sop=0, out_eop=0. in_ready=0 while rst is high. Reset mid-codeword discards the partial codeword; no eop is emitted for it.
- Latency: input accepted at edge n appears on out_data after edge n (1 cycle).
- Throughput with out_ready=1 and in_valid=1: one symbol per cycle; in_ready low for exactly 4 cycles per codeword; codeword period K+4 cycles.
- First message symbol of next codeword is accepted in the cycle after p0 is loaded, so out_data is back-to-back across codewords.
- out_data/out_sop/out_eop stable while out_valid & !out_ready.

## Test plan
- Zero message, K=8, out_ready=1: 8×0x00 -> output 12×0x00, sop on symbol 0, eop on symbol 11, in_ready low cycles 8..11.
- Impulse, K=8: seven 0x00 then 0x01 -> parity 0x0F,0x36,0x78,0x40 in that order.
- Loopback, K=251, random messages ×1000: codeword into s1 syndrome stage -> rs_syn0..3 all 0x00; with 1–2 injected symbol errors, KES+Chien restore message.
- Backpressure, K=8: random out_ready (50%) and random in_valid gaps -> output sequence identical to unstalled run; no symbol dropped or duplicated; outputs stable while stalled.
- Reset mid-codeword: assert rst after 5 of 8 symbols, then send impulse codeword -> out_valid=0 after reset edge, next codeword parity exactly 0x0F,0x36,0x78,0x40, sop on its first symbol.
- K=1: single 0x01 -> 0x01 (sop) then 0x0F,0x36,0x78,0x40 (eop on 0x40), repeated back-to-back for 3 codewords.

Source files
------------

// File: rtl/s0_rs_enc.sv
// Systematic RS(K+4,K) encoder over GF(2^8), poly 0x11D, generator roots alpha^0..alpha^3.
// Message symbols pass through one output register; four parity symbols follow each message.
module s0_rs_enc #(
  parameter int K = 251
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_sop,
  output logic       out_eop
);

  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  typedef enum logic {MSG, PAR} state_t;

  // Shift-and-add multiply; with a constant operand this folds to an XOR network.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return r;
  endfunction

  state_t        state, state_n;
  logic [CW-1:0] msg_cnt, msg_cnt_n;
  logic [1:0]    par_cnt, par_cnt_n;
  logic [7:0]    p3, p2, p1, p0;
  logic [7:0]    p3_n, p2_n, p1_n, p0_n;
  logic [7:0]    data_n;
  logic          valid_n, sop_n, eop_n;
  logic          load;
  logic [7:0]    fb;

  always_comb begin
    state_n   = state;
    msg_cnt_n = msg_cnt;
    par_cnt_n = par_cnt;
    p3_n      = p3;
    p2_n      = p2;
    p1_n      = p1;
    p0_n      = p0;
    data_n    = out_data;
    valid_n   = out_valid;
    sop_n     = out_sop;
    eop_n     = out_eop;
    load      = !out_valid || out_ready;
    fb        = in_data ^ p3;
    in_ready  = (state == MSG) && load && !rst;

    case (state)
      MSG: begin
        if (in_valid && in_ready) begin
          data_n  = in_data;
          valid_n = 1'b1;
          sop_n   = (msg_cnt == '0);
          eop_n   = 1'b0;
          p3_n    = p2 ^ gf_mul(fb, 8'h0F);
          p2_n    = p1 ^ gf_mul(fb, 8'h36);
          p1_n    = p0 ^ gf_mul(fb, 8'h78);
          p0_n    = gf_mul(fb, 8'h40);
          if (msg_cnt == LAST) begin
            msg_cnt_n = '0;
            state_n   = PAR;
          end else begin
            msg_cnt_n = msg_cnt + 1'b1;
          end
        end else if (load) begin
          valid_n = 1'b0;
        end
      end
      PAR: begin
        // Shifting zeros in leaves the remainder cleared for the next codeword.
        if (load) begin
          data_n    = p3;
          valid_n   = 1'b1;
          sop_n     = 1'b0;
          eop_n     = (par_cnt == 2'd3);
          p3_n      = p2;
          p2_n      = p1;
          p1_n      = p0;
          p0_n      = 8'h00;
          par_cnt_n = par_cnt + 2'd1;
          if (par_cnt == 2'd3) begin
            par_cnt_n = 2'd0;
            state_n   = MSG;
          end
        end
      end
      default: state_n = MSG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= MSG;
      msg_cnt   <= '0;
      par_cnt   <= 2'd0;
      p3        <= 8'h00;
      p2        <= 8'h00;
      p1        <= 8'h00;
      p0        <= 8'h00;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
    end else begin
      state     <= state_n;
      msg_cnt   <= msg_cnt_n;
      par_cnt   <= par_cnt_n;
      p3        <= p3_n;
      p2        <= p2_n;
      p1        <= p1_n;
      p0        <= p0_n;
      out_data  <= data_n;
      out_valid <= valid_n;
      out_sop   <= sop_n;
      out_eop   <= eop_n;
    end
  end

endmodule
